// File: rtl/interval_timer_pkg.sv
// Shared constants for the interval timer and its clients.
// Interval table addresses, reset defaults and FSM state encoding.
package interval_timer_pkg;

  localparam logic [1:0] INT_BASE = 2'd0;
  localparam logic [1:0] INT_EXT  = 2'd1;
  localparam logic [1:0] INT_YEL  = 2'd2;
  localparam logic [1:0] INT_WALK = 2'd3;

  localparam int DEF_BASE = 6;
  localparam int DEF_EXT  = 3;
  localparam int DEF_YEL  = 2;
  localparam int DEF_WALK = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tick_divider.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// clear restarts the count so the first tick is a full period away.
module tick_divider #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer answering start requests from the
// traffic-light FSM with a one-cycle expired pulse.
module interval_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int VALUE_W  = 4,
  parameter int DEF_BASE = interval_timer_pkg::DEF_BASE,
  parameter int DEF_EXT  = interval_timer_pkg::DEF_EXT,
  parameter int DEF_YEL  = interval_timer_pkg::DEF_YEL,
  parameter int DEF_WALK = interval_timer_pkg::DEF_WALK
) (
  input  logic               clk,
  input  logic               sys_reset,
  input  logic               start_timer,
  input  logic [1:0]         interval_address,
  input  logic               prg_sync_in,
  input  logic [1:0]         time_param_selector,
  input  logic [VALUE_W-1:0] time_value,
  output logic               expired,
  output logic               busy,
  output logic [VALUE_W-1:0] remaining
);

  import interval_timer_pkg::*;

  state_t state, state_n;

  logic [VALUE_W-1:0] tbl [4];
  logic [VALUE_W-1:0] load;
  logic [VALUE_W-1:0] rem_n;
  logic               exp_n;
  logic               busy_n;
  logic               tick;

  assign load = tbl[interval_address];

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk       (clk),
    .sys_reset (sys_reset),
    .clear     (start_timer | prg_sync_in),
    .enable    (state == RUN),
    .tick      (tick)
  );

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      tbl[0] <= VALUE_W'(DEF_BASE);
      tbl[1] <= VALUE_W'(DEF_EXT);
      tbl[2] <= VALUE_W'(DEF_YEL);
      tbl[3] <= VALUE_W'(DEF_WALK);
    end else if (prg_sync_in) begin
      tbl[time_param_selector] <= time_value;
    end
  end

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state     <= IDLE;
      remaining <= '0;
      expired   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      expired   <= exp_n;
      busy      <= busy_n;
    end
  end

  // A zero load enters RUN with remaining=0 and busy low,
  // so it expires on the very next edge without stalling.
  always_comb begin
    state_n = state;
    rem_n   = remaining;
    exp_n   = 1'b0;
    busy_n  = busy;
    if (prg_sync_in) begin
      state_n = IDLE;
      rem_n   = '0;
      busy_n  = 1'b0;
    end else if (start_timer) begin
      state_n = RUN;
      rem_n   = load;
      busy_n  = (load != '0);
    end else if (state == RUN) begin
      if (remaining == '0) begin
        state_n = IDLE;
        exp_n   = 1'b1;
        busy_n  = 1'b0;
      end else if (tick) begin
        if (remaining == VALUE_W'(1)) begin
          state_n = IDLE;
          rem_n   = '0;
          exp_n   = 1'b1;
          busy_n  = 1'b0;
        end else begin
          rem_n = remaining - VALUE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer with TICK_DIV=4.
// Deadlines are predicted from table contents and start edges.
module tb_interval_timer;

  import interval_timer_pkg::*;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval_address = 2'd0;
  logic       prg_sync_in = 1'b0;
  logic [1:0] time_param_selector = 2'd0;
  logic [3:0] time_value = 4'd0;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  always #5 clk = ~clk;

  interval_timer #(
    .TICK_DIV (TD),
    .VALUE_W  (4)
  ) dut (
    .clk                 (clk),
    .sys_reset           (sys_reset),
    .start_timer         (start_timer),
    .interval_address    (interval_address),
    .prg_sync_in         (prg_sync_in),
    .time_param_selector (time_param_selector),
    .time_value          (time_value),
    .expired             (expired),
    .busy                (busy),
    .remaining           (remaining)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ref_tbl [4];
  int exp_q [$];
  bit run_m = 1'b0;
  int st_e = 0;
  int st_n = 0;
  int last_exp = -1;
  int pulses = 0;
  int s_edge = 0;

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, req);
    end
  endtask

  function automatic void model_reset();
    ref_tbl[0] = DEF_BASE;
    ref_tbl[1] = DEF_EXT;
    ref_tbl[2] = DEF_YEL;
    ref_tbl[3] = DEF_WALK;
    exp_q.delete();
    run_m = 1'b0;
  endfunction

  // Reference model: what each edge does to the expected deadline.
  always @(posedge clk) begin
    cyc++;
    if (sys_reset) begin
      if (prg_sync_in) begin
        ref_tbl[time_param_selector] = int'(time_value);
        exp_q.delete();
        run_m = 1'b0;
      end else if (start_timer) begin
        exp_q.delete();
        st_e = cyc;
        st_n = ref_tbl[interval_address];
        run_m = 1'b1;
        exp_q.push_back(cyc + ((st_n == 0) ? 1 : st_n * TD));
      end
    end
  end

  always @(negedge clk) begin
    int t;
    int eb;
    int er;
    if (sys_reset) begin
      t = cyc - st_e;
      if (run_m && st_n > 0 && t < st_n * TD) begin
        eb = 1;
        er = st_n - t / TD;
      end else begin
        eb = 0;
        er = 0;
      end
      chk("busy", int'(busy), eb);
      chk("remaining", int'(remaining), er);
      if (expired) begin
        pulses++;
        last_exp = cyc;
        chk("expired_while_busy", int'(busy), 0);
        if (exp_q.size() == 0)
          chk("unexpected_expired", 1, 0);
        else
          chk("expiry_edge", cyc, exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
        void'(exp_q.pop_front());
        chk("missing_expired", 0, 1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] a);
    start_timer = 1'b1;
    interval_address = a;
    @(posedge clk);
    #1;
    s_edge = cyc;
    start_timer = 1'b0;
  endtask

  task automatic do_prg(input logic [1:0] sel, input logic [3:0] v);
    prg_sync_in = 1'b1;
    time_param_selector = sel;
    time_value = v;
    @(posedge clk);
    #1;
    prg_sync_in = 1'b0;
  endtask

  task automatic do_both(input logic [1:0] a, input logic [1:0] sel,
                         input logic [3:0] v);
    start_timer = 1'b1;
    interval_address = a;
    prg_sync_in = 1'b1;
    time_param_selector = sel;
    time_value = v;
    @(posedge clk);
    #1;
    start_timer = 1'b0;
    prg_sync_in = 1'b0;
  endtask

  initial begin
    int s;
    int p0;
    int r;
    model_reset();
    #2;
    chk("reset_expired", int'(expired), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_remaining", int'(remaining), 0);
    idle(2);
    sys_reset = 1'b1;
    idle(2);

    p0 = pulses;
    do_start(INT_BASE);
    s = s_edge;
    chk("load_base", int'(remaining), 6);
    chk("busy_after_start", int'(busy), 1);
    idle(30);
    chk("base_latency", last_exp - s, 24);
    chk("base_pulses", pulses - p0, 1);

    p0 = pulses;
    do_start(INT_BASE);
    idle(9);
    do_start(INT_YEL);
    s = s_edge;
    idle(30);
    chk("retrig_latency", last_exp - s, 8);
    chk("retrig_pulses", pulses - p0, 1);

    do_prg(INT_YEL, 4'd5);
    do_start(INT_YEL);
    s = s_edge;
    idle(25);
    chk("prog_yel_latency", last_exp - s, 20);
    do_start(INT_EXT);
    s = s_edge;
    idle(15);
    chk("ext_latency", last_exp - s, 12);

    p0 = pulses;
    do_start(INT_EXT);
    idle(4);
    do_prg(INT_EXT, 4'd3);
    chk("abort_busy", int'(busy), 0);
    chk("abort_remaining", int'(remaining), 0);
    idle(40);
    chk("abort_pulses", pulses - p0, 0);

    p0 = pulses;
    do_both(INT_BASE, INT_WALK, 4'd3);
    chk("both_busy", int'(busy), 0);
    idle(30);
    chk("both_pulses", pulses - p0, 0);

    do_prg(INT_WALK, 4'd0);
    do_start(INT_WALK);
    s = s_edge;
    chk("zero_busy", int'(busy), 0);
    idle(3);
    chk("zero_latency", last_exp - s, 1);

    do_prg(INT_BASE, 4'd9);
    do_start(INT_BASE);
    idle(10);
    sys_reset = 1'b0;
    model_reset();
    #1;
    chk("midreset_expired", int'(expired), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_remaining", int'(remaining), 0);
    idle(1);
    sys_reset = 1'b1;
    idle(1);
    do_start(INT_BASE);
    s = s_edge;
    idle(30);
    chk("default_restored", last_exp - s, 24);

    repeat (250) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)
        do_start(2'($urandom_range(0, 3)));
      else if (r == 4)
        do_prg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 6)));
      else if (r == 5)
        do_both(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 6)));
      else
        idle(int'($urandom_range(1, 12)));
    end
    idle(70);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
